// File: rtl/uart_rx_calc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_rx_calc                                                      |
// | 8N1 UART receiver with oversampled bit recovery and a valid/ready output   |
// | register, flagging sticky framing and overrun errors.                      |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module uart_rx_calc #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BIT_RATE   = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned N          = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rxd_pin,
  output logic [N-1:0] rx_data,
  output logic         rx_valid,
  input  logic         rx_ready,
  output logic         frame_err,
  output logic         overrun,
  output logic         busy
);

  localparam int unsigned TICK_DIV = CLK_FREQ / (BIT_RATE * OVERSAMPLE);
  localparam int unsigned TW       = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
  localparam int unsigned SW       = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BW       = (N > 1)          ? $clog2(N)          : 1;

  localparam logic [TW-1:0] C_TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] C_S_HALF    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] C_S_LAST    = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] C_B_LAST    = BW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, rx_s_q;
  logic [TW-1:0]   tcnt_q;
  logic [SW-1:0]   s_cnt_q, s_cnt_d;
  logic [BW-1:0]   b_cnt_q, b_cnt_d;
  logic [N-1:0]    shreg_q, shreg_d;
  logic [N-1:0]    rx_data_q;
  logic            rx_valid_q, frame_err_q, overrun_q;
  logic            w_tick, w_tcnt_clr, w_deliver, w_stop_bad;

  // Synchroniser idles high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rxd_pin;
      rx_s_q  <= sync1_q;
    end
  end

  assign w_tick = (tcnt_q == C_TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt_q <= '0;
    end else if (w_tcnt_clr || w_tick) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      s_cnt_q <= '0;
      b_cnt_q <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      b_cnt_q <= b_cnt_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    s_cnt_d    = s_cnt_q;
    b_cnt_d    = b_cnt_q;
    shreg_d    = shreg_q;
    w_tcnt_clr = 1'b0;
    w_deliver  = 1'b0;
    w_stop_bad = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d    = S_START;
          s_cnt_d    = '0;
          w_tcnt_clr = 1'b1;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (s_cnt_q == C_S_HALF) begin
            if (rx_s_q) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
              s_cnt_d = '0;
              b_cnt_d = '0;
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (s_cnt_q == C_S_LAST) begin
            s_cnt_d = '0;
            shreg_d = {rx_s_q, shreg_q[N-1:1]};
            if (b_cnt_q == C_B_LAST) begin
              state_d = S_STOP;
            end else begin
              b_cnt_d = b_cnt_q + BW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (s_cnt_q == C_S_LAST) begin
            s_cnt_d = '0;
            if (rx_s_q) begin
              w_deliver = 1'b1;
              state_d   = S_IDLE;
            end else begin
              w_stop_bad = 1'b1;
              state_d    = S_BREAK;
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      // A held-low line after a bad stop bit must not start a new frame.
      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (w_deliver) begin
        // A same-cycle handshake frees the register for the new byte.
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= shreg_q;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      if (w_stop_bad) begin
        frame_err_q <= 1'b1;
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_calc.sv
`default_nettype none
// Bench for uart_rx_calc: serial frames driven on rxd_pin, received bytes
// collected by a consumer monitor and compared to the queue of bytes sent.
module tb_uart_rx_calc;

  localparam int unsigned OS       = 16;
  localparam int unsigned DIV      = 4;
  localparam int unsigned BAUD     = 9600;
  localparam int unsigned CLKF     = BAUD * OS * DIV;
  localparam int          BIT_CLK  = OS * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rxd_pin = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_rx_calc #(
    .CLK_FREQ  (CLKF),
    .BIT_RATE  (BAUD),
    .OVERSAMPLE(OS),
    .N         (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rxd_pin  (rxd_pin),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Consumer side: every accepted byte is recorded.
  always @(negedge clk) begin
    if (reset && rx_valid && rx_ready) got_q.push_back(rx_data);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached (got %0d bytes)", got_q.size());
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return 8'hxx;
  endfunction

  task automatic tick_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd_pin = 1'b0;
    tick_clks(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rxd_pin = b[i];
      tick_clks(BIT_CLK);
    end
    rxd_pin = stop_bit;
    tick_clks(BIT_CLK);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    rxd_pin  = 1'b1;
    rx_ready = 1'b0;
    tick_clks(4);
    reset = 1'b1;
    tick_clks(4);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_bytes(input int n);
    int k = 0;
    while (got_q.size() < n && k < 20 * BIT_CLK) begin
      @(posedge clk);
      k++;
    end
    #1;
  endtask

  task automatic test_reset();
    tick_clks(3);
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b1;
    tick_clks(4);
  endtask

  task automatic test_single();
    do_reset();
    rx_ready = 1'b1;
    exp_q.push_back(8'h61);
    send_frame(8'h61, 1'b1);
    wait_bytes(1);
    tick_clks(BIT_CLK);
    n_cmp++; if (got_q.size() !== 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
    n_cmp++; if (got_at(0) !== exp_q[0]) begin n_bad++; $display("FAIL single_data: got %h want %h", got_at(0), exp_q[0]); end
    n_cmp++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin n_bad++; $display("FAIL single_errs: got fe=%b ov=%b want 0 0", frame_err, overrun); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_drop: got %b want 0", rx_valid); end
  endtask

  task automatic test_two();
    do_reset();
    rx_ready = 1'b1;
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h62);
    send_frame(8'h61, 1'b1);
    tick_clks(100);
    send_frame(8'h62, 1'b1);
    wait_bytes(2);
    n_cmp++; if (got_q.size() !== 2) begin n_bad++; $display("FAIL two_count: got %0d want 2", got_q.size()); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (got_at(i) !== exp_q[i]) begin n_bad++; $display("FAIL two_data[%0d]: got %h want %h", i, got_at(i), exp_q[i]); end
    end
    n_cmp++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin n_bad++; $display("FAIL two_errs: got fe=%b ov=%b want 0 0", frame_err, overrun); end
  endtask

  // Random bytes, random gaps (including zero) and a jittery consumer that
  // never stalls long enough to lose a byte.
  task automatic test_random_stream();
    bit done = 1'b0;
    do_reset();
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          logic [7:0] b;
          b = 8'($urandom);
          exp_q.push_back(b);
          send_frame(b, 1'b1);
          tick_clks((i % 4 == 0) ? 0 : int'($urandom_range(0, 12)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          rx_ready = ($urandom_range(0, 3) != 0);
          tick_clks(1);
        end
        rx_ready = 1'b1;
      end
    join
    wait_bytes(16);
    n_cmp++; if (got_q.size() !== 16) begin n_bad++; $display("FAIL rand_count: got %0d want 16", got_q.size()); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (got_at(i) !== exp_q[i]) begin n_bad++; $display("FAIL rand_data[%0d]: got %h want %h", i, got_at(i), exp_q[i]); end
    end
    n_cmp++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin n_bad++; $display("FAIL rand_errs: got fe=%b ov=%b want 0 0", frame_err, overrun); end
  endtask

  task automatic test_overrun();
    do_reset();
    rx_ready = 1'b0;
    send_frame(8'h61, 1'b1);
    send_frame(8'h62, 1'b1);
    tick_clks(BIT_CLK);
    n_cmp++; if (rx_data !== 8'h61) begin n_bad++; $display("FAIL ovr_data: got %h want 61", rx_data); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_valid: got %b want 1", rx_valid); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    rx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_valid_drop: got %b want 0", rx_valid); end
    n_cmp++; if (got_q.size() !== 1 || got_at(0) !== 8'h61) begin n_bad++; $display("FAIL ovr_accepted: got n=%0d %h want n=1 61", got_q.size(), got_at(0)); end
    tick_clks(2);
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_glitch();
    do_reset();
    rx_ready = 1'b1;
    rxd_pin  = 1'b0;
    tick_clks(20);
    rxd_pin = 1'b1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_rise: got %b want 1", busy); end
    tick_clks(BIT_CLK);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_fall: got %b want 0", busy); end
    n_cmp++; if (rx_valid !== 1'b0 || got_q.size() !== 0) begin n_bad++; $display("FAIL glitch_nobyte: got valid=%b n=%0d want 0 0", rx_valid, got_q.size()); end
    n_cmp++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin n_bad++; $display("FAIL glitch_errs: got fe=%b ov=%b want 0 0", frame_err, overrun); end
  endtask

  task automatic test_frame_err();
    do_reset();
    rx_ready = 1'b1;
    send_frame(8'h55, 1'b0);
    tick_clks(2 * BIT_CLK);
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL ferr_flag: got %b want 1", frame_err); end
    n_cmp++; if (rx_valid !== 1'b0 || got_q.size() !== 0) begin n_bad++; $display("FAIL ferr_nobyte: got valid=%b n=%0d want 0 0", rx_valid, got_q.size()); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ferr_break_busy: got %b want 1", busy); end
    rxd_pin = 1'b1;
    tick_clks(BIT_CLK);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ferr_release: got busy=%b want 0", busy); end
    send_frame(8'h33, 1'b1);
    wait_bytes(1);
    n_cmp++; if (got_q.size() !== 1 || got_at(0) !== 8'h33) begin n_bad++; $display("FAIL ferr_next_byte: got n=%0d %h want n=1 33", got_q.size(), got_at(0)); end
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL ferr_sticky: got %b want 1", frame_err); end
  endtask

  // Follows test_frame_err without a reset so rx_data and frame_err are non-zero.
  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'h7E;
    rx_ready = 1'b1;
    got_q.delete();
    rxd_pin = 1'b0;
    tick_clks(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      rxd_pin = b[i];
      tick_clks(BIT_CLK);
    end
    rxd_pin = b[4];
    tick_clks(BIT_CLK / 2);
    #3;
    reset = 1'b0;
    #1;
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL rmid_rx_data: got %h want 00", rx_data); end
    n_cmp++; if (rx_valid !== 1'b0 || overrun !== 1'b0) begin n_bad++; $display("FAIL rmid_valid_ovr: got v=%b ov=%b want 0 0", rx_valid, overrun); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL rmid_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    rxd_pin = 1'b1;
    tick_clks(4);
    reset = 1'b1;
    tick_clks(2 * BIT_CLK);
    n_cmp++; if (got_q.size() !== 0) begin n_bad++; $display("FAIL rmid_aborted: got %0d bytes want 0", got_q.size()); end
    send_frame(b, 1'b1);
    wait_bytes(1);
    n_cmp++; if (got_q.size() !== 1 || got_at(0) !== b) begin n_bad++; $display("FAIL rmid_clean_frame: got n=%0d %h want n=1 %h", got_q.size(), got_at(0), b); end
    n_cmp++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin n_bad++; $display("FAIL rmid_errs: got fe=%b ov=%b want 0 0", frame_err, overrun); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two();
    test_random_stream();
    test_overrun();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
